// File: rtl/soc_mem_frontend_if.sv
`default_nettype none
// ============================================================================
//  Module   : soc_mem_frontend_if
//  Purpose  : Single-outstanding memory port between soc_mem_frontend and the
//             SDRAM wrapper. The front end drives address/data/strobes. The
//             memory answers with a 1-cycle ready pulse and read data.
//  Modports : master - front end (drives addr/din/we/oe)
//             slave  - memory side (drives ready/dout)
//  Revision : 1.0  initial release
// ============================================================================
interface soc_mem_frontend_if #(
    parameter int unsigned AW = 25,
    parameter int unsigned DW = 8
);
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic          mem_oe;
    logic          mem_ready;
    logic [DW-1:0] mem_dout;

    modport master (
        output mem_addr, mem_din, mem_we, mem_oe,
        input  mem_ready, mem_dout
    );

    modport slave (
        input  mem_addr, mem_din, mem_we, mem_oe,
        output mem_ready, mem_dout
    );
endinterface
`default_nettype wire

// File: rtl/soc_mem_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : soc_mem_frontend
//  Purpose  : Memory front end for MiST SoC tops. It arbitrates NCH client
//             channels and the data_io ROM download stream onto one
//             single-outstanding memory port. It also generates the CPU reset
//             hold sequence and the sticky rom_loaded flag.
//  Ports    : clk, reset_n      clock, synchronous active-low reset
//             i_ext_reset       OSD/IO reset request (level)
//             i_dl_*            download stream (active, byte strobe, addr, data)
//             i_ch_* / o_ch_*   NCH client channels (req/we/addr/wdata, ack/rdata)
//             mem               memory port (soc_mem_frontend_if.master)
//             o_cpu_reset       active-high CPU/system reset
//             o_rom_loaded      sticky: a download has completed
//             o_dl_overrun      sticky: a download byte was dropped
//  Config   : WRITE_PROTECT_EN  when defined, channel writes at or above
//                               DL_BASE are suppressed once the ROM is loaded.
//                               Such a write is acked without a memory cycle.
//  Revision : 1.0  initial release
// ============================================================================
module soc_mem_frontend #(
    parameter int unsigned   NCH      = 2,
    parameter int unsigned   AW       = 25,
    parameter int unsigned   DW       = 8,
    parameter logic [AW-1:0] DL_BASE  = 25'h1800000,
    parameter int unsigned   DL_AW    = 14,
    parameter int unsigned   RST_HOLD = 255
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_ext_reset,
    input  logic              i_dl_active,
    input  logic              i_dl_wr,
    input  logic [AW-1:0]     i_dl_addr,
    input  logic [DW-1:0]     i_dl_data,
    input  logic [NCH-1:0]    i_ch_req,
    input  logic [NCH-1:0]    i_ch_we,
    input  logic [NCH*AW-1:0] i_ch_addr,
    input  logic [NCH*DW-1:0] i_ch_wdata,
    output logic [NCH-1:0]    o_ch_ack,
    output logic [DW-1:0]     o_ch_rdata,
    soc_mem_frontend_if.master mem,
    output logic              o_cpu_reset,
    output logic              o_rom_loaded,
    output logic              o_dl_overrun
);

    localparam int unsigned   c_IW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned   c_CW       = (RST_HOLD > 1) ? $clog2(RST_HOLD + 1) : 1;
    localparam logic [c_CW-1:0] c_HOLD_MAX = c_CW'(RST_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DL   = 2'd1,
        ST_CH   = 2'd2,
        ST_WP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Download buffer (one entry)
    logic              r_dl_full;
    logic [AW-1:0]     r_dl_addr;
    logic [DW-1:0]     r_dl_data;
    logic              r_dl_overrun;

    // Client access bookkeeping
    logic [c_IW-1:0]   r_gnt;
    logic              r_rd;
    logic [NCH-1:0]    r_ch_ack;
    logic [DW-1:0]     r_ch_rdata;

    // Memory port registers
    logic [AW-1:0]     r_mem_addr;
    logic [DW-1:0]     r_mem_din;
    logic              r_mem_we;
    logic              r_mem_oe;

    // Reset sequencer / load tracking
    logic [c_CW-1:0]   r_hold;
    logic              r_dl_active_q;
    logic              r_rom_loaded;

    // Combinational decode
    logic              w_grant_ch;
    logic [c_IW-1:0]   w_grant_idx;
    logic [AW-1:0]     w_sel_addr;
    logic [DW-1:0]     w_sel_wdata;
    logic              w_sel_we;
    logic              w_wp_hit;
    logic              w_take_dl;
    logic              w_take_ch;
    logic              w_dl_free;
    logic              w_dl_accept;
    logic [AW-1:0]     w_dl_addr;
    logic              w_unused_dl_hi;

    // Only the low DL_AW download address bits are meaningful.
    assign w_unused_dl_hi = |i_dl_addr[AW-1:DL_AW];
    assign w_dl_addr      = DL_BASE + AW'(i_dl_addr[DL_AW-1:0]);

    // Fixed priority: lowest index wins. A channel whose ack is on the wire
    // this cycle still has its request up, so it is masked to avoid a
    // spurious second grant.
    always_comb begin
        w_grant_ch  = 1'b0;
        w_grant_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_ch_req[i] && !r_ch_ack[i]) begin
                w_grant_ch  = 1'b1;
                w_grant_idx = c_IW'(i);
            end
        end
    end

    assign w_sel_addr  = i_ch_addr[w_grant_idx*AW +: AW];
    assign w_sel_wdata = i_ch_wdata[w_grant_idx*DW +: DW];
    assign w_sel_we    = i_ch_we[w_grant_idx];

`ifdef WRITE_PROTECT_EN
    assign w_wp_hit = r_rom_loaded && w_sel_we && (w_sel_addr >= DL_BASE);
`else
    assign w_wp_hit = 1'b0;
`endif

    // A pending download byte always beats the clients. Clients are held off
    // for the whole download window.
    assign w_take_dl   = (r_state == ST_IDLE) && r_dl_full;
    assign w_take_ch   = (r_state == ST_IDLE) && !r_dl_full && !i_dl_active && w_grant_ch;
    assign w_dl_free   = (r_state == ST_DL) && mem.mem_ready;
    // The buffer may be refilled in the same cycle it is being freed.
    assign w_dl_accept = i_dl_wr && i_dl_active && (!r_dl_full || w_dl_free);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_take_dl) begin
                    w_state_nxt = ST_DL;
                end else if (w_take_ch) begin
                    w_state_nxt = w_wp_hit ? ST_WP : ST_CH;
                end
            end
            ST_DL, ST_CH: begin
                if (mem.mem_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WP:   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Memory port and client response datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_we   <= 1'b0;
            r_mem_oe   <= 1'b0;
            r_gnt      <= '0;
            r_rd       <= 1'b0;
            r_ch_ack   <= '0;
            r_ch_rdata <= '0;
        end else begin
            r_ch_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_take_dl) begin
                        r_mem_addr <= r_dl_addr;
                        r_mem_din  <= r_dl_data;
                        r_mem_we   <= 1'b1;
                    end else if (w_take_ch) begin
                        r_gnt <= w_grant_idx;
                        r_rd  <= !w_sel_we;
                        // A protected write never reaches the memory port.
                        if (!w_wp_hit) begin
                            r_mem_addr <= w_sel_addr;
                            r_mem_din  <= w_sel_wdata;
                            r_mem_we   <= w_sel_we;
                            r_mem_oe   <= !w_sel_we;
                        end
                    end
                end
                ST_DL: begin
                    if (mem.mem_ready) begin
                        r_mem_we <= 1'b0;
                    end
                end
                ST_CH: begin
                    if (mem.mem_ready) begin
                        r_mem_we        <= 1'b0;
                        r_mem_oe        <= 1'b0;
                        r_ch_ack[r_gnt] <= 1'b1;
                        if (r_rd) begin
                            r_ch_rdata <= mem.mem_dout;
                        end
                    end
                end
                ST_WP: begin
                    r_ch_ack[r_gnt] <= 1'b1;
                end
                default: begin
                    r_mem_we <= 1'b0;
                    r_mem_oe <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Download buffer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dl_full    <= 1'b0;
            r_dl_addr    <= '0;
            r_dl_data    <= '0;
            r_dl_overrun <= 1'b0;
        end else begin
            if (w_dl_accept) begin
                r_dl_full <= 1'b1;
                r_dl_addr <= w_dl_addr;
                r_dl_data <= i_dl_data;
            end else begin
                if (w_dl_free) begin
                    r_dl_full <= 1'b0;
                end
                if (i_dl_wr && i_dl_active) begin
                    r_dl_overrun <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // CPU reset hold counter and ROM-loaded flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hold        <= '0;
            r_dl_active_q <= 1'b0;
            r_rom_loaded  <= 1'b0;
        end else begin
            r_dl_active_q <= i_dl_active;
            if (i_ext_reset || i_dl_active) begin
                r_hold <= '0;
            end else if (r_hold != c_HOLD_MAX) begin
                r_hold <= r_hold + 1'b1;
            end
            if (r_dl_active_q && !i_dl_active) begin
                r_rom_loaded <= 1'b1;
            end
        end
    end

    assign mem.mem_addr = r_mem_addr;
    assign mem.mem_din  = r_mem_din;
    assign mem.mem_we   = r_mem_we;
    assign mem.mem_oe   = r_mem_oe;

    assign o_ch_ack     = r_ch_ack;
    assign o_ch_rdata   = r_ch_rdata;
    assign o_cpu_reset  = (r_hold != c_HOLD_MAX);
    assign o_rom_loaded = r_rom_loaded;
    assign o_dl_overrun = r_dl_overrun;

endmodule
`default_nettype wire

// File: tb/tb_soc_mem_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_soc_mem_frontend
//  Purpose  : Self-checking bench for soc_mem_frontend with a memory responder
//             (ready two cycles after strobe) and a reference memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_soc_mem_frontend;
    localparam int NCH = 2;
    localparam int AW = 25;
    localparam int DW = 8;
    localparam int DL_AW = 14;
    localparam int RST_HOLD = 255;
    localparam int RDY_DLY = 2;
    localparam logic [AW-1:0] DL_BASE = 25'h1800000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ext_reset = 1'b0;
    logic dl_active = 1'b0;
    logic dl_wr = 1'b0;
    logic [AW-1:0] dl_addr = '0;
    logic [DW-1:0] dl_data = '0;
    logic [NCH-1:0] ch_req = '0;
    logic [NCH-1:0] ch_we = '0;
    logic [NCH*AW-1:0] ch_addr = '0;
    logic [NCH*DW-1:0] ch_wdata = '0;
    logic [NCH-1:0] ch_ack;
    logic [DW-1:0] ch_rdata;
    logic cpu_reset, rom_loaded, dl_overrun;

    soc_mem_frontend_if #(.AW(AW), .DW(DW)) mem ();

    soc_mem_frontend #(
        .NCH(NCH), .AW(AW), .DW(DW), .DL_BASE(DL_BASE), .DL_AW(DL_AW), .RST_HOLD(RST_HOLD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_ext_reset(ext_reset),
        .i_dl_active(dl_active), .i_dl_wr(dl_wr), .i_dl_addr(dl_addr), .i_dl_data(dl_data),
        .i_ch_req(ch_req), .i_ch_we(ch_we), .i_ch_addr(ch_addr), .i_ch_wdata(ch_wdata),
        .o_ch_ack(ch_ack), .o_ch_rdata(ch_rdata), .mem(mem),
        .o_cpu_reset(cpu_reset), .o_rom_loaded(rom_loaded), .o_dl_overrun(dl_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- memory responder ----------------
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    logic [DW-1:0] mem_arr [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    wr_t wlog[$];
    wr_t exp_w[$];
    logic m_ready = 1'b0;
    logic [DW-1:0] m_dout = '0;
    logic ready_hold = 1'b0;
    int mcnt = 0;

    assign mem.mem_ready = m_ready;
    assign mem.mem_dout  = m_dout;

    function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 8'h5A;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    always @(negedge clk) begin
        m_ready = 1'b0;
        if (!(mem.mem_we || mem.mem_oe)) begin
            mcnt = 0;
        end else if (!ready_hold) begin
            mcnt++;
            if (mcnt == RDY_DLY) begin
                m_ready = 1'b1;
                if (mem.mem_we) begin
                    mem_arr[mem.mem_addr] = mem.mem_din;
                    wlog.push_back({mem.mem_addr, mem.mem_din});
                end else begin
                    m_dout = mem_arr.exists(mem.mem_addr) ? mem_arr[mem.mem_addr] : fill(mem.mem_addr);
                end
            end
        end
    end

    // ---------------- client batch driver (stimulus/recording only) ----------------
    logic          b_we    [NCH];
    logic [AW-1:0] b_addr  [NCH];
    logic [DW-1:0] b_wdata [NCH];
    int            b_lat   [NCH];
    int            b_acks  [NCH];
    logic [DW-1:0] b_rdata [NCH];
    logic [DW-1:0] e_rdata [NCH];
    bit            b_timeout;

    task automatic run_batch(input logic [NCH-1:0] mask);
        logic [NCH-1:0] pend;
        int n;
        for (int i = 0; i < NCH; i++) begin
            ch_we[i] = b_we[i];
            ch_addr[i*AW +: AW] = b_addr[i];
            ch_wdata[i*DW +: DW] = b_wdata[i];
            b_lat[i] = 0; b_acks[i] = 0; b_rdata[i] = '0;
        end
        ch_req = mask; pend = mask; n = 0; b_timeout = 1'b0;
        while (pend != '0 && n < 200) begin
            @(negedge clk); n++;
            for (int i = 0; i < NCH; i++) begin
                if (ch_ack[i]) begin
                    b_acks[i]++;
                    if (pend[i]) begin
                        b_lat[i] = n; b_rdata[i] = ch_rdata; pend[i] = 1'b0; ch_req[i] = 1'b0;
                    end
                end
            end
        end
        if (pend != '0) b_timeout = 1'b1;
        ch_req = '0;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) if (ch_ack[i]) b_acks[i]++;
        end
    endtask

    // Reference: serve the batch in priority order, each access three cycles apart.
    task automatic model_batch(input logic [NCH-1:0] mask);
        for (int i = 0; i < NCH; i++) begin
            e_rdata[i] = '0;
            if (mask[i]) begin
                if (b_we[i]) begin
                    ref_mem[b_addr[i]] = b_wdata[i];
                    exp_w.push_back({b_addr[i], b_wdata[i]});
                end else begin
                    e_rdata[i] = ref_rd(b_addr[i]);
                end
            end
        end
    endtask

    task automatic dl_pulse(input logic [AW-1:0] a, input logic [DW-1:0] d);
        dl_addr = a; dl_data = d; dl_wr = 1'b1;
        @(negedge clk);
        dl_wr = 1'b0;
    endtask

    function automatic logic [AW-1:0] dl_target(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = '0;
        off[DL_AW-1:0] = a[DL_AW-1:0];
        return DL_BASE + off;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ch_ack !== '0) begin failures++; $display("FAIL reset_ack: got %b expected 0", ch_ack); end
        checks++; if (ch_rdata !== '0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", ch_rdata); end
        checks++; if ({mem.mem_we, mem.mem_oe} !== 2'b00) begin failures++; $display("FAIL reset_strobes: got %b expected 00", {mem.mem_we, mem.mem_oe}); end
        checks++; if ({mem.mem_addr, mem.mem_din} !== '0) begin failures++; $display("FAIL reset_addr_din: got %h/%h expected 0", mem.mem_addr, mem.mem_din); end
        checks++; if ({cpu_reset, rom_loaded, dl_overrun} !== 3'b100) begin failures++; $display("FAIL reset_flags: got %b expected 100", {cpu_reset, rom_loaded, dl_overrun}); end
        reset_n = 1'b1;
        n = 0;
        while (cpu_reset === 1'b1 && n < 1000) begin n++; @(negedge clk); end
        checks++; if (n !== RST_HOLD) begin failures++; $display("FAIL reset_hold_len: got %0d expected %0d", n, RST_HOLD); end
        ext_reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL ext_reset_hold: got %b expected 1", cpu_reset); end
        ext_reset = 1'b0;
        n = 0;
        while (cpu_reset === 1'b1 && n < 1000) begin n++; @(negedge clk); end
        checks++; if (n !== RST_HOLD) begin failures++; $display("FAIL ext_reset_len: got %0d expected %0d", n, RST_HOLD); end
    endtask

    task automatic test_channels_random();
        logic [NCH-1:0] mask;
        int rank;
        for (int it = 0; it < 16; it++) begin
            mask = NCH'($urandom_range(1, 3));
            for (int i = 0; i < NCH; i++) begin
                b_we[i] = 1'($urandom_range(0, 1));
                b_addr[i] = AW'($urandom_range(0, 15));
                b_wdata[i] = DW'($urandom);
            end
            exp_w.delete(); wlog.delete();
            model_batch(mask);
            run_batch(mask);
            checks++; if (b_timeout) begin failures++; $display("FAIL rnd_timeout it=%0d: got timeout expected all acks", it); end
            rank = 0;
            for (int i = 0; i < NCH; i++) begin
                checks++; if (b_acks[i] !== int'(mask[i])) begin failures++; $display("FAIL rnd_ack_count it=%0d ch=%0d: got %0d expected %0d", it, i, b_acks[i], mask[i]); end
                if (mask[i]) begin
                    rank++;
                    checks++; if (b_lat[i] !== 3 * rank) begin failures++; $display("FAIL rnd_latency it=%0d ch=%0d: got %0d expected %0d", it, i, b_lat[i], 3 * rank); end
                    if (!b_we[i]) begin
                        checks++; if (b_rdata[i] !== e_rdata[i]) begin failures++; $display("FAIL rnd_rdata it=%0d ch=%0d: got %h expected %h", it, i, b_rdata[i], e_rdata[i]); end
                    end
                end
            end
            checks++; if (wlog.size() !== exp_w.size()) begin failures++; $display("FAIL rnd_wcount it=%0d: got %0d expected %0d", it, wlog.size(), exp_w.size()); end
            else for (int k = 0; k < exp_w.size(); k++) begin
                checks++; if (wlog[k] !== exp_w[k]) begin failures++; $display("FAIL rnd_write it=%0d: got %h expected %h", it, wlog[k], exp_w[k]); end
            end
        end
    endtask

    task automatic test_priority();
        b_we[0] = 1'b1; b_addr[0] = 25'h40;  b_wdata[0] = 8'h77;
        b_we[1] = 1'b0; b_addr[1] = 25'h100; b_wdata[1] = 8'h00;
        exp_w.delete(); wlog.delete();
        model_batch(2'b11);
        run_batch(2'b11);
        checks++; if (b_lat[0] !== 3) begin failures++; $display("FAIL prio_ch0_lat: got %0d expected 3", b_lat[0]); end
        checks++; if (b_lat[1] !== 6) begin failures++; $display("FAIL prio_ch1_lat: got %0d expected 6", b_lat[1]); end
        checks++; if (b_rdata[1] !== 8'h3C) begin failures++; $display("FAIL prio_ch1_rdata: got %h expected 3c", b_rdata[1]); end
        checks++; if (wlog.size() !== 1 || wlog[0] !== wr_t'({25'h40, 8'h77})) begin failures++; $display("FAIL prio_write: got %0d entries expected 1 at 40=77", wlog.size()); end
    endtask

    task automatic test_download();
        int n;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        exp_w.delete(); wlog.delete();
        @(negedge clk);
        dl_active = 1'b1;
        @(negedge clk);
        dl_pulse(25'h5, 8'hA5);
        exp_w.push_back({25'h1800005, 8'hA5});
        n = 0;
        while (mem.mem_we !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (mem.mem_we !== 1'b1) begin failures++; $display("FAIL dl_we: got %b expected 1", mem.mem_we); end
        checks++; if (mem.mem_addr !== 25'h1800005) begin failures++; $display("FAIL dl_addr: got %h expected 1800005", mem.mem_addr); end
        checks++; if (mem.mem_din !== 8'hA5) begin failures++; $display("FAIL dl_din: got %h expected a5", mem.mem_din); end
        repeat (6) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            a = AW'($urandom); d = DW'($urandom);
            dl_pulse(a, d);
            exp_w.push_back({dl_target(a), d});
            ref_mem[dl_target(a)] = d;
            repeat (8) @(negedge clk);
        end
        checks++; if ({cpu_reset, rom_loaded} !== 2'b10) begin failures++; $display("FAIL dl_flags_during: got %b expected 10", {cpu_reset, rom_loaded}); end
        checks++; if (wlog.size() !== exp_w.size()) begin failures++; $display("FAIL dl_wcount: got %0d expected %0d", wlog.size(), exp_w.size()); end
        else for (int k = 0; k < exp_w.size(); k++) begin
            checks++; if (wlog[k] !== exp_w[k]) begin failures++; $display("FAIL dl_write k=%0d: got %h expected %h", k, wlog[k], exp_w[k]); end
        end
        dl_active = 1'b0;
        n = 0;
        while (cpu_reset === 1'b1 && n < 1000) begin n++; @(negedge clk); end
        checks++; if (n !== RST_HOLD) begin failures++; $display("FAIL dl_reset_len: got %0d expected %0d", n, RST_HOLD); end
        checks++; if (rom_loaded !== 1'b1) begin failures++; $display("FAIL dl_rom_loaded: got %b expected 1", rom_loaded); end
    endtask

    task automatic test_dl_blocks_clients();
        int acks, strobes;
        dl_active = 1'b1;
        ch_we = '0; ch_addr[0 +: AW] = 25'h3; ch_req = 2'b01;
        acks = 0; strobes = 0;
        repeat (10) begin
            @(negedge clk);
            if (ch_ack != '0) acks++;
            if (mem.mem_we || mem.mem_oe) strobes++;
        end
        checks++; if (acks + strobes !== 0) begin failures++; $display("FAIL dlblock_activity: got %0d acks %0d strobes expected 0", acks, strobes); end
        dl_active = 1'b0;
        b_we[0] = 1'b0; b_addr[0] = 25'h3; b_wdata[0] = '0;
        exp_w.delete(); wlog.delete();
        model_batch(2'b01);
        run_batch(2'b01);
        checks++; if (b_acks[0] !== 1) begin failures++; $display("FAIL dlblock_served: got %0d acks expected 1", b_acks[0]); end
        checks++; if (b_rdata[0] !== e_rdata[0]) begin failures++; $display("FAIL dlblock_rdata: got %h expected %h", b_rdata[0], e_rdata[0]); end
    endtask

    task automatic test_dl_simultaneous();
        int n;
        exp_w.delete(); wlog.delete();
        dl_active = 1'b1;
        @(negedge clk);
        dl_pulse(25'h11, 8'h5C);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (mem.mem_ready !== 1'b1 && n < 20);
        checks++; if (mem.mem_ready !== 1'b1) begin failures++; $display("FAIL sim_ready: got %b expected 1", mem.mem_ready); end
        dl_addr = 25'h12; dl_data = 8'hC3; dl_wr = 1'b1;
        @(negedge clk);
        dl_wr = 1'b0;
        repeat (10) @(negedge clk);
        dl_active = 1'b0;
        exp_w.push_back({dl_target(25'h11), 8'h5C});
        exp_w.push_back({dl_target(25'h12), 8'hC3});
        ref_mem[dl_target(25'h11)] = 8'h5C;
        ref_mem[dl_target(25'h12)] = 8'hC3;
        checks++; if (dl_overrun !== 1'b0) begin failures++; $display("FAIL sim_overrun: got %b expected 0", dl_overrun); end
        checks++; if (wlog.size() !== 2) begin failures++; $display("FAIL sim_wcount: got %0d expected 2", wlog.size()); end
        else begin
            checks++; if (wlog[1] !== exp_w[1]) begin failures++; $display("FAIL sim_second: got %h expected %h", wlog[1], exp_w[1]); end
        end
        repeat (300) @(negedge clk);
    endtask

    task automatic test_write_protect();
        checks++; if (rom_loaded !== 1'b1) begin failures++; $display("FAIL wp_precond: got %b expected 1", rom_loaded); end
        b_we[0] = 1'b1; b_addr[0] = 25'h1800010; b_wdata[0] = 8'h99;
        exp_w.delete(); wlog.delete();
        run_batch(2'b01);
`ifdef WRITE_PROTECT_EN
        checks++; if (b_lat[0] !== 2) begin failures++; $display("FAIL wp_latency: got %0d expected 2", b_lat[0]); end
        checks++; if (wlog.size() !== 0) begin failures++; $display("FAIL wp_suppressed: got %0d writes expected 0", wlog.size()); end
`else
        ref_mem[25'h1800010] = 8'h99;
        checks++; if (b_lat[0] !== 3) begin failures++; $display("FAIL wp_latency: got %0d expected 3", b_lat[0]); end
        checks++; if (wlog.size() !== 1) begin failures++; $display("FAIL wp_written: got %0d writes expected 1", wlog.size()); end
`endif
        b_addr[0] = 25'h20; b_wdata[0] = 8'h42;
        exp_w.delete(); wlog.delete();
        model_batch(2'b01);
        run_batch(2'b01);
        checks++; if (b_lat[0] !== 3 || wlog.size() !== 1) begin failures++; $display("FAIL wp_low_write: got lat %0d writes %0d expected 3/1", b_lat[0], wlog.size()); end
    endtask

    task automatic test_overrun();
        exp_w.delete(); wlog.delete();
        dl_active = 1'b1; ready_hold = 1'b1;
        @(negedge clk);
        dl_pulse(25'h30, 8'h1E);
        repeat (3) @(negedge clk);
        dl_pulse(25'h31, 8'hE1);
        checks++; if (dl_overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b expected 1", dl_overrun); end
        ready_hold = 1'b0;
        repeat (20) @(negedge clk);
        dl_active = 1'b0;
        ref_mem[dl_target(25'h30)] = 8'h1E;
        checks++; if (wlog.size() !== 1 || wlog[0] !== wr_t'({dl_target(25'h30), 8'h1E})) begin failures++; $display("FAIL ovr_writes: got %0d entries expected only first byte", wlog.size()); end
        repeat (5) @(negedge clk);
        checks++; if (dl_overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b expected 1", dl_overrun); end
    endtask

    task automatic test_reset_mid_access();
        int n, acks, strobes;
        ready_hold = 1'b1;
        ch_we = '0; ch_addr[0 +: AW] = 25'h7; ch_req = 2'b01;
        n = 0;
        while (mem.mem_oe !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        checks++; if (mem.mem_oe !== 1'b1) begin failures++; $display("FAIL mid_oe: got %b expected 1", mem.mem_oe); end
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if ({mem.mem_we, mem.mem_oe, ch_ack} !== 4'b0000) begin failures++; $display("FAIL mid_reset_outs: got %b expected 0000", {mem.mem_we, mem.mem_oe, ch_ack}); end
        reset_n = 1'b1; ch_req = '0; ready_hold = 1'b0;
        acks = 0; strobes = 0;
        repeat (10) begin
            @(negedge clk);
            if (ch_ack != '0) acks++;
            if (mem.mem_we || mem.mem_oe) strobes++;
        end
        checks++; if (acks + strobes !== 0) begin failures++; $display("FAIL mid_idle: got %0d acks %0d strobes expected 0", acks, strobes); end
        checks++; if ({rom_loaded, dl_overrun} !== 2'b00) begin failures++; $display("FAIL mid_flags: got %b expected 00", {rom_loaded, dl_overrun}); end
    endtask

    initial begin
        mem_arr[25'h100] = 8'h3C;
        ref_mem[25'h100] = 8'h3C;
        test_reset();
        test_channels_random();
        test_priority();
        test_download();
        test_dl_blocks_clients();
        test_dl_simultaneous();
        test_write_protect();
        test_overrun();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
